// File: rtl/acc_iomem_pkg.sv
// Shared definitions for the accelerator iomem register map and the
// pixel fetch master's control FSM.
package acc_iomem_pkg;

    // Accelerator register offsets relative to its base address.
    localparam logic [3:0] CTRL_OFS   = 4'h0;
    localparam logic [3:0] STAT_OFS   = 4'h4;
    localparam logic [7:0] PIX_OFS    = 8'h8;

    localparam logic [3:0] WSTRB_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        POLL_RD,
        PIX_RD,
        MEM_WR,
        DONE
    } state_t;

    // Byte-strobe mask covering the lowest 'lanes' byte lanes (4 or more = all).
    function automatic logic [3:0] lane_mask(input logic [2:0] lanes);
        case (lanes)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return WSTRB_FULL;
        endcase
    endfunction

endpackage

// File: rtl/pixel_fetch_master_if.sv
// iomem request/response bundle between a bus initiator and a responder.
interface pixel_fetch_master_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/pixel_word_packer.sv
// Collects 8-bit pixels little-endian into a 32-bit word and reports how
// many byte lanes hold data, together with the matching write strobe.
module pixel_word_packer
    import acc_iomem_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  pix,
    output logic [31:0] word,
    output logic [3:0]  strb,
    output logic [2:0]  lane_cnt
);

    // Insert each pushed pixel at the next free lane; clear empties the word so unused lanes read 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            word     <= '0;
            lane_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            lane_cnt <= '0;
        end else if (push) begin
            word[{lane_cnt[1:0], 3'b000} +: 8] <= pix;
            lane_cnt                          <= lane_cnt + 3'd1;
        end
    end

    assign strb = lane_mask(lane_cnt);

endmodule

// File: rtl/pixel_fetch_master.sv
// iomem initiator: configures the accelerator, polls for pixels, reads them
// and writes packed 4-pixel words to a destination buffer.
module pixel_fetch_master
    import acc_iomem_pkg::*;
#(
    parameter logic [31:0] ACC_BASE   = 32'h0200_0000,
    parameter int          NUM_PIXELS = 1024,
    parameter int          POLL_LIMIT = 256
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [31:0]                 dst_base,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err,
    output logic [15:0]                 px_count,
    pixel_fetch_master_if.master        iomem
);

    localparam logic [15:0] LAST_PX  = 16'(NUM_PIXELS);
    localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);

    state_t      state, state_next;
    logic [31:0] dst_q;
    logic [1:0]  mode_q;
    logic [15:0] word_idx;
    logic [15:0] poll_cnt;
    logic        req_valid;
    logic        ack;
    logic        accept;
    logic        poll_expire;
    logic        pk_push;
    logic        pk_clear;
    logic [31:0] pk_word;
    logic [3:0]  pk_strb;
    logic [2:0]  pk_lanes;
    logic        unused_bits;

    assign ack         = req_valid && iomem.ready;
    assign accept      = (state == IDLE) && start;
    assign poll_expire = (poll_cnt + 16'd1) == POLL_MAX;
    assign iomem.valid = req_valid;
    assign unused_bits = ^{iomem.rdata[31:8], dst_base[1:0]};

    pixel_word_packer u_packer (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (pk_clear),
        .push     (pk_push),
        .pix      (iomem.rdata[7:0]),
        .word     (pk_word),
        .strb     (pk_strb),
        .lane_cnt (pk_lanes)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus the request fields each state presents on the bus.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        iomem.addr  = '0;
        iomem.wstrb = '0;
        iomem.wdata = '0;
        pk_push     = 1'b0;
        pk_clear    = accept;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CFG_WR;
            end
            CFG_WR: begin
                iomem.addr  = ACC_BASE + 32'(CTRL_OFS);
                iomem.wstrb = WSTRB_FULL;
                iomem.wdata = {30'b0, mode_q};
                if (ack) state_next = POLL_RD;
            end
            POLL_RD: begin
                iomem.addr = ACC_BASE + 32'(STAT_OFS);
                if (ack) begin
                    if (iomem.rdata[0])   state_next = PIX_RD;
                    else if (poll_expire) state_next = DONE;
                end
            end
            PIX_RD: begin
                iomem.addr = ACC_BASE + 32'(PIX_OFS);
                if (ack) begin
                    pk_push = 1'b1;
                    // Flush on a full word or on the frame's final pixel.
                    if (pk_lanes == 3'd3 || (px_count + 16'd1) == LAST_PX) state_next = MEM_WR;
                    else                                                   state_next = POLL_RD;
                end
            end
            MEM_WR: begin
                iomem.addr  = dst_q + {14'b0, word_idx, 2'b00};
                iomem.wstrb = pk_strb;
                iomem.wdata = pk_word;
                if (ack) begin
                    pk_clear   = 1'b1;
                    state_next = (px_count == LAST_PX) ? DONE : POLL_RD;
                end
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Request handshake, frame context and counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_valid   <= 1'b0;
            dst_q       <= '0;
            mode_q      <= '0;
            word_idx    <= '0;
            poll_cnt    <= '0;
            px_count    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Drop valid right after the ack; the state advances on the same
            // edge, so the next request rises one idle cycle later.
            if (ack)
                req_valid <= 1'b0;
            else if (state inside {CFG_WR, POLL_RD, PIX_RD, MEM_WR})
                req_valid <= 1'b1;

            if (accept) begin
                dst_q       <= {dst_base[31:2], 2'b00};
                mode_q      <= mode;
                word_idx    <= '0;
                poll_cnt    <= '0;
                px_count    <= '0;
                timeout_err <= 1'b0;
            end

            if (state == POLL_RD && ack) begin
                if (iomem.rdata[0]) begin
                    poll_cnt <= '0;
                end else begin
                    poll_cnt <= poll_cnt + 16'd1;
                    if (poll_expire) timeout_err <= 1'b1;
                end
            end

            if (pk_push) px_count <= px_count + 16'd1;

            if (state == MEM_WR && ack) word_idx <= word_idx + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_fetch_master.sv
// Directed bench for pixel_fetch_master: two instances (8 pixels with a short
// poll limit, and 6 pixels for the partial final word) share one iomem
// responder model; every acked request is compared against a scoreboard.
module tb_pixel_fetch_master;

    localparam logic [31:0] ACC_BASE = 32'h0200_0000;
    localparam logic [31:0] A_CTRL   = ACC_BASE;
    localparam logic [31:0] A_STAT   = ACC_BASE + 32'h4;
    localparam logic [31:0] A_PIX    = ACC_BASE + 32'h8;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  start_v;
    logic [1:0]  mode;
    logic [31:0] dst_base;
    logic [1:0]  busy_v, done_v, terr_v;
    logic [15:0] pxc_v [2];
    logic [1:0]  valid_v;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  wstrb_v [2];
    logic [1:0]  ready_v = 2'b00;
    logic [31:0] rdata_v = 32'h0;

    // Responder configuration, written only by the stimulus block.
    logic        sel         = 1'b0;
    int          rsp_delay   = 1;
    int          stat_zero_n = 0;
    logic        stat_stuck  = 1'b0;
    logic        rsp_clear   = 1'b0;

    // Responder-owned state.
    int          wait_cnt  = 0;
    int          stat_left = 0;
    int          bus_viol  = 0;
    logic [7:0]  pix_val   = 8'h10;
    logic        holding   = 1'b0;
    logic        ack_d     = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;
    txn_t        obs_mem [256];
    logic [7:0]  obs_wr = 8'd0;

    // Stimulus-owned scoreboard state.
    txn_t        exp_q [$];
    logic [7:0]  obs_rd = 8'd0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NPIX = (g == 0) ? 8 : 6;
        localparam int PLIM = (g == 0) ? 4 : 256;

        pixel_fetch_master_if bus ();

        pixel_fetch_master #(
            .ACC_BASE   (ACC_BASE),
            .NUM_PIXELS (NPIX),
            .POLL_LIMIT (PLIM)
        ) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .start       (start_v[g]),
            .mode        (mode),
            .dst_base    (dst_base),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .timeout_err (terr_v[g]),
            .px_count    (pxc_v[g]),
            .iomem       (bus.master)
        );

        assign bus.ready  = ready_v[g];
        assign bus.rdata  = rdata_v;
        assign valid_v[g] = bus.valid;
        assign addr_v[g]  = bus.addr;
        assign wdata_v[g] = bus.wdata;
        assign wstrb_v[g] = bus.wstrb;
    end

    // Responder model for the selected instance: acks rsp_delay cycles after
    // valid, records each acked request and flags bus-rule violations.
    always @(posedge clk) begin
        ready_v <= 2'b00;
        ack_d   <= ready_v[sel];
        if (ack_d && valid_v[sel]) bus_viol <= bus_viol + 1;
        if (rsp_clear) begin
            pix_val   <= 8'h10;
            stat_left <= stat_zero_n;
            wait_cnt  <= 0;
            holding   <= 1'b0;
        end else if (valid_v[sel] && !ready_v[sel]) begin
            if (holding && (addr_v[sel] != h_addr || wstrb_v[sel] != h_wstrb || wdata_v[sel] != h_wdata))
                bus_viol <= bus_viol + 1;
            holding <= 1'b1;
            h_addr  <= addr_v[sel];
            h_wstrb <= wstrb_v[sel];
            h_wdata <= wdata_v[sel];
            if (wait_cnt + 1 >= rsp_delay) begin
                ready_v[sel]     <= 1'b1;
                wait_cnt         <= 0;
                obs_mem[obs_wr]  <= {addr_v[sel], wstrb_v[sel], wdata_v[sel]};
                obs_wr           <= obs_wr + 8'd1;
                if (addr_v[sel] == A_STAT) begin
                    if (stat_stuck) begin
                        rdata_v <= {31'h2AAA_AAAA, 1'b0};
                    end else if (stat_left > 0) begin
                        rdata_v   <= {31'h2AAA_AAAA, 1'b0};
                        stat_left <= stat_left - 1;
                    end else begin
                        rdata_v <= {31'h2AAA_AAAA, 1'b1};
                    end
                end else if (addr_v[sel] == A_PIX) begin
                    rdata_v <= {24'hABCDEF, pix_val};
                    pix_val <= pix_val + 8'd1;
                end else begin
                    rdata_v <= 32'hDEAD_BEEF;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
            holding  <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_q.push_back({a, s, d});
    endtask

    task automatic push_ctrl(input logic [1:0] m);
        push(A_CTRL, 4'hF, {30'b0, m});
    endtask

    // 'polls' STATUS reads followed by one PIXEL read.
    task automatic push_px(input int polls);
        for (int i = 0; i < polls; i++) push(A_STAT, 4'h0, 32'h0);
        push(A_PIX, 4'h0, 32'h0);
    endtask

    task automatic check_txn(input string tag);
        txn_t e, o;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            if (obs_rd != obs_wr) got = 1'b1;
            else @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s.timeout: observed no request, expected addr 0x%0h", tag, e.addr);
        end
        if (got) begin
            o = obs_mem[obs_rd];
            obs_rd++;
            chk({tag, ".addr"}, o.addr, e.addr);
            chk({tag, ".wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
            if (e.wstrb != 4'h0) chk({tag, ".wdata"}, o.wdata, e.wdata);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) check_txn(tag);
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (done_v[sel]) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s.done: observed no done pulse, expected one", tag);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = 2'b00;
    endtask

    task automatic begin_test(input logic s, input int delay, input int zeros, input logic stuck);
        @(negedge clk);
        sel         = s;
        rsp_delay   = delay;
        stat_zero_n = zeros;
        stat_stuck  = stuck;
        rsp_clear   = 1'b1;
        @(negedge clk);
        rsp_clear   = 1'b0;
        obs_rd      = obs_wr;
        exp_q.delete();
    endtask

    initial begin
        bit got;
        rstn     = 1'b0;
        start_v  = 2'b00;
        mode     = 2'b00;
        dst_base = 32'h0;
        rsp_clear = 1'b1;
        repeat (3) @(negedge clk);
        rsp_clear = 1'b0;

        // Reset state.
        chk("rst.busy", 32'(busy_v[0]), 32'h0);
        chk("rst.done", 32'(done_v[0]), 32'h0);
        chk("rst.timeout_err", 32'(terr_v[0]), 32'h0);
        chk("rst.px_count", 32'(pxc_v[0]), 32'h0);
        chk("rst.valid", 32'(valid_v), 32'h0);
        chk("rst.addr", addr_v[0], 32'h0);
        chk("rst.wstrb", 32'(wstrb_v[0]), 32'h0);
        chk("rst.wdata", wdata_v[0], 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Full 8-pixel frame; second start while busy must be ignored.
        begin_test(1'b0, 1, 0, 1'b0);
        mode     = 2'b10;
        dst_base = 32'h0000_1000;
        push_ctrl(2'b10);
        for (int i = 0; i < 4; i++) push_px(1);
        push(32'h1000, 4'hF, 32'h1312_1110);
        for (int i = 0; i < 4; i++) push_px(1);
        push(32'h1004, 4'hF, 32'h1716_1514);
        pulse_start();
        chk("f8.busy_after_start", 32'(busy_v[0]), 32'h1);
        mode = 2'b01;
        pulse_start();
        drain("f8");
        wait_done("f8");
        chk("f8.px_count", 32'(pxc_v[0]), 32'd8);
        chk("f8.timeout_err", 32'(terr_v[0]), 32'h0);
        chk("f8.busy_at_done", 32'(busy_v[0]), 32'h0);
        // start coincident with done is dropped.
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = 2'b00;
        chk("f8.done_one_cycle", 32'(done_v[0]), 32'h0);
        repeat (5) @(negedge clk);
        chk("f8.start_at_done_ignored", 32'(busy_v[0]), 32'h0);
        chk("f8.no_extra_requests", 32'(obs_wr - obs_rd), 32'h0);

        // 6-pixel frame: partial final word, dst_base low bits ignored.
        begin_test(1'b1, 1, 0, 1'b0);
        mode     = 2'b01;
        dst_base = 32'h0000_1002;
        push_ctrl(2'b01);
        for (int i = 0; i < 4; i++) push_px(1);
        push(32'h1000, 4'hF, 32'h1312_1110);
        for (int i = 0; i < 2; i++) push_px(1);
        push(32'h1004, 4'b0011, 32'h0000_1514);
        pulse_start();
        drain("f6");
        wait_done("f6");
        chk("f6.px_count", 32'(pxc_v[1]), 32'd6);

        // Three not-ready polls before the first pixel, slow responder.
        begin_test(1'b0, 5, 3, 1'b0);
        mode     = 2'b11;
        dst_base = 32'h0000_2000;
        push_ctrl(2'b11);
        push_px(4);
        for (int i = 0; i < 3; i++) push_px(1);
        push(32'h2000, 4'hF, 32'h1312_1110);
        for (int i = 0; i < 4; i++) push_px(1);
        push(32'h2004, 4'hF, 32'h1716_1514);
        pulse_start();
        drain("poll3");
        wait_done("poll3");
        chk("poll3.px_count", 32'(pxc_v[0]), 32'd8);
        chk("poll3.timeout_err", 32'(terr_v[0]), 32'h0);
        chk("poll3.bus_rules", 32'(bus_viol), 32'h0);

        // Status stuck at 0: timeout after POLL_LIMIT reads, no memory write.
        begin_test(1'b0, 1, 0, 1'b1);
        mode     = 2'b00;
        dst_base = 32'h0000_1000;
        push_ctrl(2'b00);
        for (int i = 0; i < 4; i++) push(A_STAT, 4'h0, 32'h0);
        pulse_start();
        drain("tmo");
        wait_done("tmo");
        chk("tmo.timeout_err", 32'(terr_v[0]), 32'h1);
        chk("tmo.px_count", 32'(pxc_v[0]), 32'h0);
        repeat (5) @(negedge clk);
        chk("tmo.no_extra_requests", 32'(obs_wr - obs_rd), 32'h0);

        // Reset while a memory write waits for its ack.
        begin_test(1'b0, 20, 0, 1'b0);
        mode = 2'b11;
        push_ctrl(2'b11);
        for (int i = 0; i < 4; i++) push_px(1);
        pulse_start();
        chk("rstwr.timeout_err_cleared", 32'(terr_v[0]), 32'h0);
        drain("rstwr");
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (valid_v[0] && wstrb_v[0] == 4'hF) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL rstwr.memwr_seen: observed no write request, expected one");
        end
        chk("rstwr.memwr_addr", addr_v[0], 32'h1000);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwr.valid", 32'(valid_v[0]), 32'h0);
        chk("rstwr.busy", 32'(busy_v[0]), 32'h0);
        chk("rstwr.done", 32'(done_v[0]), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Fresh frame after reset starts with the CTRL write.
        begin_test(1'b0, 1, 0, 1'b0);
        mode     = 2'b01;
        dst_base = 32'h0000_3000;
        push_ctrl(2'b01);
        for (int i = 0; i < 4; i++) push_px(1);
        push(32'h3000, 4'hF, 32'h1312_1110);
        for (int i = 0; i < 4; i++) push_px(1);
        push(32'h3004, 4'hF, 32'h1716_1514);
        pulse_start();
        chk("rerun.px_count_start", 32'(pxc_v[0]), 32'h0);
        drain("rerun");
        wait_done("rerun");
        chk("rerun.px_count", 32'(pxc_v[0]), 32'd8);

        repeat (3) @(negedge clk);
        chk("bus_rules", 32'(bus_viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
